// File: rtl/operand_entry_pkg.sv
`default_nettype none
// ============================================================================
// Module  : operand_entry_pkg
// Brief   : Shared key codes, state encoding and helpers for operand_entry.
// Revision: 1.0 - initial release
// ============================================================================
package operand_entry_pkg;

  localparam logic [3:0] KEY_NEG    = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_DELETE = 4'hC;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } entry_state_t;

  // Decimal digit keys are the codes 0..9.
  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  // Largest value an entry of 'digits' decimal digits can take (10^digits - 1).
  function automatic logic [63:0] max_decimal(input int digits);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_entry_bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module  : bcd_to_bin_seq
// Brief   : Sequential BCD-to-binary converter. One digit per cycle,
//           MSB first, acc <- acc*10 + digit, OUT_W-bit unsigned arithmetic.
//           o_done flags the cycle whose edge completes the last digit and
//           o_result carries that final value during the same cycle.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq
  import operand_entry_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int OUT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [4*NUM_DIGITS-1:0] i_bcd,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [OUT_W-1:0]        o_result
);

  localparam int c_cnt_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [c_cnt_w-1:0]      r_cnt;
  logic [OUT_W-1:0]        r_acc;
  logic                    r_busy;
  logic [3:0]              w_digit;
  logic [OUT_W-1:0]        w_next;

  // r_cnt is the index of the digit consumed this cycle (MSB digit first).
  assign w_digit = 4'(r_bcd >> {r_cnt, 2'b00});
  assign w_next  = (r_acc * OUT_W'(10)) + OUT_W'(w_digit);

  // Latch the entry on start, then fold in one digit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_bcd  <= i_bcd;
      r_acc  <= '0;
      r_cnt  <= c_cnt_w'(NUM_DIGITS - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_next;
      if (r_cnt == '0) r_busy <= 1'b0;
      else             r_cnt  <= r_cnt - c_cnt_w'(1);
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_busy && (r_cnt == '0);
  assign o_result = w_next;

endmodule
`default_nettype wire

// File: rtl/operand_entry.sv
`default_nettype none
// ============================================================================
// Module  : operand_entry
// Brief   : Keypad operand-entry controller. Collects up to NUM_DIGITS
//           decimal digits per operand (with delete), converts each entry to
//           binary and stores NUM_OPERANDS operands, then flags completion.
//           Optional macro OPERAND_ENTRY_NEG_EN enables the sign key and
//           stores negative entries in two's complement.
// Revision: 1.0 - initial release
// ============================================================================
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int NUM_OPERANDS = 2,
  parameter int OUT_W        = 16
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [3:0]                                          key,
  input  logic                                                key_valid,
  output logic                                                key_ready,
  output logic [4*NUM_DIGITS-1:0]                             disp_bcd,
  output logic [$clog2(NUM_DIGITS+1)-1:0]                     disp_count,
  output logic                                                disp_neg,
  output logic [((NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1)-1:0] operand_idx,
  output logic [NUM_OPERANDS*OUT_W-1:0]                       operands,
  output logic                                                operands_valid
);

  localparam int c_bcd_w = 4 * NUM_DIGITS;
  localparam int c_cnt_w = $clog2(NUM_DIGITS + 1);
  localparam int c_idx_w = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam logic [63:0] c_max_val = max_decimal(NUM_DIGITS);
`ifdef OPERAND_ENTRY_NEG_EN
  localparam logic [63:0] c_limit = (64'd1 << (OUT_W - 1)) - 64'd1;
`else
  localparam logic [63:0] c_limit = (OUT_W >= 64) ? {64{1'b1}} : ((64'd1 << OUT_W) - 64'd1);
`endif

  // Refuse to build a configuration whose largest entry cannot be stored.
  generate
    if (c_max_val > c_limit) begin : g_width_check
      $error("operand_entry: OUT_W too narrow for NUM_DIGITS");
    end
  endgenerate

  entry_state_t         r_state;
  logic [c_bcd_w-1:0]   r_bcd;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_neg;
  logic [c_idx_w-1:0]   r_idx;
  logic [OUT_W-1:0]     r_ops [NUM_OPERANDS];
  logic                 r_valid;

  logic                 w_accept;
  logic                 w_start;
  logic                 w_conv_busy;
  logic                 w_conv_done;
  logic                 w_conv_last;
  logic [OUT_W-1:0]     w_conv_result;
  logic [OUT_W-1:0]     w_store;

  assign key_ready = (r_state == ENTRY) || (r_state == DONE);
  assign w_accept  = key_valid && key_ready;
  assign w_start   = w_accept && (r_state == ENTRY) && (key == KEY_ENTER);

  // The converter latches the entry at the enter edge, so the display
  // register is free to be cleared when the last digit lands.
  bcd_to_bin_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .OUT_W      (OUT_W)
  ) u_conv (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_bcd    (r_bcd),
    .o_busy   (w_conv_busy),
    .o_done   (w_conv_done),
    .o_result (w_conv_result)
  );

  assign w_conv_last = (r_state == CONVERT) && w_conv_busy && w_conv_done;

`ifdef OPERAND_ENTRY_NEG_EN
  // Negating zero yields zero, so a "-0" entry stores 0.
  assign w_store = r_neg ? (~w_conv_result + OUT_W'(1)) : w_conv_result;
`else
  assign w_store = w_conv_result;
`endif

  // Keypad FSM, digit shift register and operand storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ENTRY;
      r_bcd   <= '0;
      r_count <= '0;
      r_neg   <= 1'b0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < NUM_OPERANDS; i++) r_ops[i] <= '0;
    end else begin
      case (r_state)
        ENTRY: begin
          if (w_accept) begin
            if (is_digit(key)) begin
              if (r_count < c_cnt_w'(NUM_DIGITS)) begin
                r_bcd   <= (r_bcd << 4) | c_bcd_w'(key);
                r_count <= r_count + c_cnt_w'(1);
              end
            end else if (key == KEY_DELETE) begin
              if (r_count != '0) begin
                r_bcd   <= r_bcd >> 4;
                r_count <= r_count - c_cnt_w'(1);
              end
            end else if (key == KEY_ENTER) begin
              r_state <= CONVERT;
`ifdef OPERAND_ENTRY_NEG_EN
            end else if (key == KEY_NEG) begin
              r_neg <= ~r_neg;
`endif
            end
          end
        end
        CONVERT: begin
          if (w_conv_last) begin
            r_ops[r_idx] <= w_store;
            r_bcd        <= '0;
            r_count      <= '0;
            r_neg        <= 1'b0;
            if (r_idx == c_idx_w'(NUM_OPERANDS - 1)) begin
              r_state <= DONE;
              r_valid <= 1'b1;
            end else begin
              r_idx   <= r_idx + c_idx_w'(1);
              r_state <= ENTRY;
            end
          end
        end
        DONE: begin
          if (w_accept && (key == KEY_ENTER)) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_state <= ENTRY;
            for (int i = 0; i < NUM_OPERANDS; i++) r_ops[i] <= '0;
          end
        end
        default: begin
          r_state <= ENTRY;
          r_bcd   <= '0;
          r_count <= '0;
          r_neg   <= 1'b0;
          r_idx   <= '0;
          r_valid <= 1'b0;
          for (int i = 0; i < NUM_OPERANDS; i++) r_ops[i] <= '0;
        end
      endcase
    end
  end

  // Flatten operand storage onto the output bus, operand i at [i*OUT_W +: OUT_W].
  generate
    for (genvar g = 0; g < NUM_OPERANDS; g++) begin : g_flat
      assign operands[g*OUT_W +: OUT_W] = r_ops[g];
    end
  endgenerate

  assign disp_bcd       = r_bcd;
  assign disp_count     = r_count;
  assign disp_neg       = r_neg;
  assign operand_idx    = r_idx;
  assign operands_valid = r_valid;

endmodule
`default_nettype wire
